// File: rtl/alu_ctrl_pkg.sv
// M-extension op codes, sequencer states and latency-counter width
// shared by the multiply/divide sequencer slice.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01110;
    localparam logic [4:0] OP_MULH   = 5'b01111;
    localparam logic [4:0] OP_MULHSU = 5'b10000;
    localparam logic [4:0] OP_MULHU  = 5'b10001;
    localparam logic [4:0] OP_DIV    = 5'b10010;
    localparam logic [4:0] OP_DIVU   = 5'b10011;
    localparam logic [4:0] OP_REM    = 5'b10100;
    localparam logic [4:0] OP_REMU   = 5'b10101;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_WAIT,
        ST_DONE
    } md_state_t;

    function automatic logic is_mul_op(
        input logic [4:0] op
    );
        return (op == OP_MUL) || (op == OP_MULH)
            || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(
        input logic [4:0] op
    );
        return (op == OP_DIV) || (op == OP_DIVU)
            || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Combinational RISC-V divide corner cases: divide by zero and
// signed overflow, resolved without the divider units.
module muldiv_special_case
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  is_special,
    output logic [DATA_WIDTH-1:0] special_result
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic div_zero;
    logic sgn_ovf;
    logic is_quo;
    logic is_rem;

    assign div_zero = (divisor == '0);
    assign sgn_ovf  = (dividend == MOST_NEG) && (divisor == '1);
    assign is_quo   = (op == OP_DIV) || (op == OP_DIVU);
    assign is_rem   = (op == OP_REM) || (op == OP_REMU);

    always_comb begin
        is_special     = 1'b1;
        special_result = '0;
        unique case (1'b1)
            is_quo && div_zero:          special_result = '1;
            is_rem && div_zero:          special_result = dividend;
            (op == OP_DIV) && sgn_ovf:   special_result = dividend;
            (op == OP_REM) && sgn_ovf:   special_result = '0;
            default:                     is_special = 1'b0;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues one M-extension op to the shared mul/div units, counts out
// their latency and returns the result over a valid/ready handshake.
module muldiv_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] src1_value,
    input  logic [DATA_WIDTH-1:0] src2_value,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    input  logic [DATA_WIDTH-1:0] mul_lo,
    input  logic [DATA_WIDTH-1:0] mul_hi_ss,
    input  logic [DATA_WIDTH-1:0] mul_hi_su,
    input  logic [DATA_WIDTH-1:0] mul_hi_uu,
    input  logic [DATA_WIDTH-1:0] quot_s,
    input  logic [DATA_WIDTH-1:0] quot_u,
    input  logic [DATA_WIDTH-1:0] rem_s,
    input  logic [DATA_WIDTH-1:0] rem_u,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  busy
);

    md_state_t             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [4:0]            op_q;
    logic                  spec_q;
    logic [DATA_WIDTH-1:0] spec_res_q;
    logic                  is_special;
    logic [DATA_WIDTH-1:0] special_result;
    logic [DATA_WIDTH-1:0] unit_res;
    logic                  legal;
    logic                  accept;
    logic                  capture;

    muldiv_special_case #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_special (
        .op            (alu_ctrl),
        .dividend      (src1_value),
        .divisor       (src2_value),
        .is_special    (is_special),
        .special_result(special_result)
    );

    assign legal  = is_mul_op(alu_ctrl) || is_div_op(alu_ctrl);
    assign accept = req_valid && legal && !flush
                 && (state == ST_IDLE);

    // Corner cases still spend one wait cycle (cnt=0) so every
    // response leaves from the same capture point.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_special) begin
                            state_nxt = ST_DIV_WAIT;
                            cnt_nxt   = '0;
                        end else if (is_mul_op(alu_ctrl)) begin
                            state_nxt = ST_MUL_WAIT;
                            cnt_nxt   = CNT_W'(MUL_LATENCY);
                        end else begin
                            state_nxt = ST_DIV_WAIT;
                            cnt_nxt   = CNT_W'(DIV_LATENCY);
                        end
                    end
                end
                ST_MUL_WAIT, ST_DIV_WAIT: begin
                    if (cnt == '0) begin
                        state_nxt = ST_DONE;
                        capture   = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        unit_res = '0;
        unique case (1'b1)
            op_q == OP_MUL:    unit_res = mul_lo;
            op_q == OP_MULH:   unit_res = mul_hi_ss;
            op_q == OP_MULHSU: unit_res = mul_hi_su;
            op_q == OP_MULHU:  unit_res = mul_hi_uu;
            op_q == OP_DIV:    unit_res = quot_s;
            op_q == OP_DIVU:   unit_res = quot_u;
            op_q == OP_REM:    unit_res = rem_s;
            op_q == OP_REMU:   unit_res = rem_u;
            default:           unit_res = '0;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        rsp_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            rsp_result <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_q       <= alu_ctrl;
                op_a       <= src1_value;
                op_b       <= src2_value;
                spec_q     <= is_special;
                spec_res_q <= special_result;
            end
            if (capture) begin
                rsp_result <= spec_q ? spec_res_q : unit_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with pipelined stub
// multiplier/divider units fed from op_a/op_b.
module tb_muldiv_sequencer;

    localparam int W     = 32;
    localparam int MUL_L = 2;
    localparam int DIV_L = 8;

    localparam logic [4:0] C_MUL    = 5'b01110;
    localparam logic [4:0] C_MULH   = 5'b01111;
    localparam logic [4:0] C_MULHU  = 5'b10001;
    localparam logic [4:0] C_DIV    = 5'b10010;
    localparam logic [4:0] C_DIVU   = 5'b10011;
    localparam logic [4:0] C_REM    = 5'b10100;
    localparam logic [4:0] C_REMU   = 5'b10101;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [4:0]   alu_ctrl = '0;
    logic [W-1:0] src1_value = '0;
    logic [W-1:0] src2_value = '0;
    logic         flush = 1'b0;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] mul_lo, mul_hi_ss, mul_hi_su, mul_hi_uu;
    logic [W-1:0] quot_s, quot_u, rem_s, rem_u;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         busy;

    muldiv_sequencer #(
        .DATA_WIDTH (W),
        .MUL_LATENCY(MUL_L),
        .DIV_LATENCY(DIV_L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .alu_ctrl  (alu_ctrl),
        .src1_value(src1_value),
        .src2_value(src2_value),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_lo    (mul_lo),
        .mul_hi_ss (mul_hi_ss),
        .mul_hi_su (mul_hi_su),
        .mul_hi_uu (mul_hi_uu),
        .quot_s    (quot_s),
        .quot_u    (quot_u),
        .rem_s     (rem_s),
        .rem_u     (rem_u),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub units: L-deep pipelines; 0xDEADBEEF marks cases the
    // sequencer must never take from the divider.
    logic [63:0]  p_lo, p_ss, p_su, p_uu;
    logic [W-1:0] d_qs, d_qu, d_rs, d_ru;
    logic         d_ovf;
    logic [127:0] mp [MUL_L];
    logic [127:0] dp [DIV_L];

    always_comb begin
        p_lo = {32'b0, op_a} * {32'b0, op_b};
        p_ss = $signed({{32{op_a[31]}}, op_a})
             * $signed({{32{op_b[31]}}, op_b});
        p_su = $signed({{32{op_a[31]}}, op_a})
             * $signed({32'b0, op_b});
        p_uu = p_lo;
        d_ovf = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        d_qu = 32'hDEAD_BEEF;
        d_ru = 32'hDEAD_BEEF;
        d_qs = 32'hDEAD_BEEF;
        d_rs = 32'hDEAD_BEEF;
        if (op_b != 0) begin
            d_qu = op_a / op_b;
            d_ru = op_a % op_b;
            if (!d_ovf) begin
                d_qs = $signed(op_a) / $signed(op_b);
                d_rs = $signed(op_a) % $signed(op_b);
            end
        end
    end

    always @(posedge clk) begin
        mp[0] <= {p_lo[31:0], p_ss[63:32], p_su[63:32], p_uu[63:32]};
        for (int i = 1; i < MUL_L; i++) mp[i] <= mp[i-1];
        dp[0] <= {d_qs, d_qu, d_rs, d_ru};
        for (int i = 1; i < DIV_L; i++) dp[i] <= dp[i-1];
    end

    assign {mul_lo, mul_hi_ss, mul_hi_su, mul_hi_uu} = mp[MUL_L-1];
    assign {quot_s, quot_u, rem_s, rem_u} = dp[DIV_L-1];

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic have_cur = 1'b0;
    logic mon_en = 1'b0;
    logic exp_busy;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid) begin
                if (!have_cur) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_rsp: got %h (cycle %0d)",
                                 rsp_result, cyc);
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1'b1;
                        chk("rsp_cycle", cyc, cur.due);
                    end
                end
                if (have_cur) chk("rsp_result", rsp_result, cur.res);
            end else begin
                have_cur = 1'b0;
            end
            if (q.size() != 0) begin
                chk("op_a", op_a, q[0].a);
                chk("op_b", op_b, q[0].b);
            end
            exp_busy = (q.size() != 0) || have_cur;
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            chk("req_ready", {31'b0, req_ready}, {31'b0, !exp_busy});
        end
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res,
                         input int lat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: req_ready stuck low op %b", op);
            return;
        end
        req_valid  = 1'b1;
        alu_ctrl   = op;
        src1_value = a;
        src2_value = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        q.push_back('{res, a, b, cyc + lat});
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || have_cur) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_op_a", op_a, '0);
        chk("rst_op_b", op_b, '0);
        chk("rst_result", rsp_result, '0);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        mon_en = 1'b1;

        issue(C_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_L + 1);
        issue(C_DIVU, 32'd100, 32'd7, 32'd14, DIV_L + 1);
        issue(C_REMU, 32'd100, 32'd7, 32'd2, DIV_L + 1);
        issue(C_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue(C_REM, 32'd5, 32'd0, 32'd5, 1);
        issue(C_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue(C_REMU, 32'd7, 32'd0, 32'd7, 1);
        issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        issue(C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_L + 1);
        issue(C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_L + 1);
        drain();

        // Illegal op code: must be ignored entirely.
        @(negedge clk);
        req_valid = 1'b1;
        alu_ctrl  = 5'b00000;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        chk("illegal_busy", {31'b0, busy}, 32'd0);

        // Consumer back-pressure in DONE.
        rsp_ready = 1'b0;
        issue(C_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MUL_L + 1);
        wait_valid(20);
        repeat (4) begin
            @(negedge clk);
            chk("stall_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", {31'b0, req_ready}, 32'd1);
        chk("release_valid", {31'b0, rsp_valid}, 32'd0);

        // Flush three cycles into a divide.
        issue(C_DIV, 32'd1000, 32'd3, 32'd333, DIV_L + 1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        q.delete();
        issue(C_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, MUL_L + 1);
        drain();
        repeat (DIV_L + 2) @(negedge clk);

        // Reset in the middle of a multiply.
        issue(C_MUL, 32'd9, 32'd9, 32'd81, MUL_L + 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        chk_reset_vals();
        repeat (MUL_L + 2) @(negedge clk);

        issue(C_MUL, 32'd3, 32'd4, 32'd12, MUL_L + 1);
        drain();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
